// File: rtl/display_selector.sv
// Display source selector with idle auto-return to source 0 and per-digit blinking.
// A select strobe picks one of NUM_SRC digit buses; after TIMEOUT idle cycles on a
// non-zero source the selector falls back to source 0 and pulses timeout_pulse.
// Masked digit groups of a non-zero source blink with a BLINK_HALF half-period.
module display_selector #(
   parameter int NUM_SRC    = 3,
   parameter int NUM_DIG    = 3,
   parameter int DIG_W      = 7,
   parameter int TIMEOUT    = 16,
   parameter int BLINK_HALF = 4,
   parameter logic [DIG_W-1:0] BLANK = '0,
   localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_SRC*NUM_DIG*DIG_W-1:0] src_data,
   input  logic [SEL_W-1:0]                 sel,
   input  logic                             sel_valid,
   input  logic [NUM_DIG-1:0]               blink_mask,
   output logic [NUM_DIG*DIG_W-1:0]         dig_out,
   output logic [SEL_W-1:0]                 cur_sel,
   output logic                             timeout_pulse
);

   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_HALF - 1);
   // One extra bit so NUM_SRC itself is representable when it is a power of two.
   localparam logic [SEL_W:0]   SRC_LIMIT = (SEL_W + 1)'(NUM_SRC);

   logic [TMR_W-1:0]         timer;
   logic [BLK_W-1:0]         blink_cnt;
   logic                     phase;
   logic                     accept;
   logic                     timeout_hit;
   logic [DIG_W-1:0]         src_dig [NUM_SRC][NUM_DIG];
   logic [NUM_DIG*DIG_W-1:0] dig_next;

   // Unflatten the source bus so digits can be picked by source index.
   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
         assign src_dig[s][d] = src_data[(s*NUM_DIG + d)*DIG_W +: DIG_W];
      end
   end

   // Out-of-range requests are dropped entirely; a valid select always beats the timeout.
   always_comb begin
      accept      = sel_valid && ({1'b0, sel} < SRC_LIMIT);
      timeout_hit = (cur_sel != '0) && (timer == TMR_LAST) && !accept;
   end

   // Next display value: source cur_sel with masked digits blanked in the off phase.
   always_comb begin
      dig_next = '0;
      for (int d = 0; d < NUM_DIG; d++) begin
         if ((cur_sel != '0) && !phase && blink_mask[d]) begin
            dig_next[d*DIG_W +: DIG_W] = BLANK;
         end else begin
            dig_next[d*DIG_W +: DIG_W] = src_dig[cur_sel][d];
         end
      end
   end

   // Selection, idle timer, blink generator and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_sel       <= '0;
         timer         <= '0;
         blink_cnt     <= '0;
         phase         <= 1'b1;
         timeout_pulse <= 1'b0;
         dig_out       <= '0;
      end else begin
         dig_out       <= dig_next;
         timeout_pulse <= timeout_hit;

         if (accept) begin
            cur_sel <= sel;
            timer   <= '0;
         end else if (timeout_hit) begin
            cur_sel <= '0;
            timer   <= '0;
         end else if (cur_sel != '0) begin
            timer   <= timer + 1'b1;
         end

         // A new selection restarts the blink cycle in the visible half.
         if (accept) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
         end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_selector.sv
// Bench for display_selector: directed scenarios plus randomized traffic,
// all compared against an age-based behavioural model of the selector.
module tb_display_selector;

   localparam int NUM_SRC    = 3;
   localparam int NUM_DIG    = 3;
   localparam int DIG_W      = 7;
   localparam int TIMEOUT    = 16;
   localparam int BLINK_HALF = 4;
   localparam int SEL_W      = 2;
   localparam int SRC_W      = NUM_SRC*NUM_DIG*DIG_W;
   localparam int OUT_W      = NUM_DIG*DIG_W;
   localparam logic [DIG_W-1:0] BLANK = '0;

   logic              clk = 1'b0;
   logic              reset;
   logic [SRC_W-1:0]  src_data;
   logic [SEL_W-1:0]  sel;
   logic              sel_valid;
   logic [NUM_DIG-1:0] blink_mask;
   logic [OUT_W-1:0]  dig_out;
   logic [SEL_W-1:0]  cur_sel;
   logic              timeout_pulse;

   int checks = 0;
   int passes = 0;

   // Model state: selection plus ages (edges since last accept / blink restart).
   int               m_sel = 0;
   int               sel_age = 0;
   int               blink_age = 0;
   logic             m_pulse = 1'b0;
   logic [OUT_W-1:0] m_dig = '0;

   display_selector #(
      .NUM_SRC(NUM_SRC), .NUM_DIG(NUM_DIG), .DIG_W(DIG_W),
      .TIMEOUT(TIMEOUT), .BLINK_HALF(BLINK_HALF), .BLANK(BLANK)
   ) dut (
      .clk(clk), .reset(reset), .src_data(src_data), .sel(sel),
      .sel_valid(sel_valid), .blink_mask(blink_mask), .dig_out(dig_out),
      .cur_sel(cur_sel), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      logic [OUT_W-1:0] nd;
      bit vis;
      if (reset) begin
         m_sel = 0; sel_age = 0; blink_age = 0; m_pulse = 1'b0; m_dig = '0;
      end else begin
         vis = ((blink_age / BLINK_HALF) % 2) == 0;
         nd = '0;
         for (int d = 0; d < NUM_DIG; d++) begin
            if (m_sel != 0 && !vis && blink_mask[d])
               nd[d*DIG_W +: DIG_W] = BLANK;
            else
               nd[d*DIG_W +: DIG_W] = src_data[(m_sel*NUM_DIG + d)*DIG_W +: DIG_W];
         end
         m_dig = nd;
         m_pulse = 1'b0;
         if (sel_valid && int'(sel) < NUM_SRC) begin
            m_sel = int'(sel); sel_age = 0; blink_age = 0;
         end else begin
            blink_age++;
            if (m_sel != 0) begin
               sel_age++;
               if (sel_age == TIMEOUT) begin
                  m_sel = 0; sel_age = 0; m_pulse = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("cur_sel", 64'(cur_sel), 64'(m_sel));
      check("dig_out", 64'(dig_out), 64'(m_dig));
      check("timeout_pulse", 64'(timeout_pulse), 64'(m_pulse));
   endtask

   task automatic pulse_sel(input int s);
      sel_valid = 1'b1;
      sel = SEL_W'(s);
      step();
      sel_valid = 1'b0;
   endtask

   initial begin
      logic [63:0]      rnd;
      logic [OUT_W-1:0] exp_src0;
      logic [DIG_W-1:0] exp_d1;

      reset = 1'b1; sel = '0; sel_valid = 1'b0; blink_mask = '0;
      for (int s = 0; s < NUM_SRC; s++)
         for (int d = 0; d < NUM_DIG; d++)
            src_data[(s*NUM_DIG + d)*DIG_W +: DIG_W] = DIG_W'(16*s + d);

      // Reset for two cycles, then release.
      step();
      step();
      check("rst_cur_sel", 64'(cur_sel), 64'd0);
      check("rst_dig_out", 64'(dig_out), 64'd0);
      reset = 1'b0;
      step();
      exp_src0 = {7'h02, 7'h01, 7'h00};
      check("post_rst_dig", 64'(dig_out), 64'(exp_src0));
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_no_pulse", 64'(timeout_pulse), 64'd0);
      end

      // Select source 2, then let it time out.
      pulse_sel(2);
      check("sel2_cur", 64'(cur_sel), 64'd2);
      for (int n = 1; n <= 17; n++) begin
         step();
         check("sel2_pulse_timing", 64'(timeout_pulse), (n == 16) ? 64'd1 : 64'd0);
         if (n == 1) check("sel2_dig", 64'(dig_out), 64'({7'h22, 7'h21, 7'h20}));
         if (n == 17) check("revert_dig", 64'(dig_out), 64'(exp_src0));
      end

      // Blink digit 1 of source 1.
      blink_mask = 3'b010;
      pulse_sel(1);
      for (int n = 1; n <= 12; n++) begin
         step();
         exp_d1 = (((n - 1) / BLINK_HALF) % 2 == 0) ? 7'h11 : BLANK;
         check("blink_d1", 64'(dig_out[DIG_W +: DIG_W]), 64'(exp_d1));
         check("blink_d0", 64'(dig_out[0 +: DIG_W]), 64'h10);
         check("blink_d2", 64'(dig_out[2*DIG_W +: DIG_W]), 64'h12);
      end
      // Source 0 never blinks.
      pulse_sel(0);
      for (int n = 1; n <= 10; n++) begin
         step();
         check("src0_steady", 64'(dig_out), 64'(exp_src0));
      end

      // Out-of-range select while on source 1 changes nothing.
      pulse_sel(1);
      for (int n = 1; n <= 4; n++) step();
      pulse_sel(3);
      check("oor_cur", 64'(cur_sel), 64'd1);
      for (int n = 6; n <= 16; n++) begin
         step();
         check("oor_pulse_timing", 64'(timeout_pulse), (n == 16) ? 64'd1 : 64'd0);
      end

      // Select on the exact timeout cycle wins over the revert.
      blink_mask = 3'b000;
      pulse_sel(1);
      for (int n = 1; n <= 15; n++) step();
      pulse_sel(1);
      check("race_no_pulse", 64'(timeout_pulse), 64'd0);
      check("race_cur", 64'(cur_sel), 64'd1);
      for (int n = 1; n <= 16; n++) begin
         step();
         check("race_revert_timing", 64'(timeout_pulse), (n == 16) ? 64'd1 : 64'd0);
      end

      // Reset in the middle of a source 2 blink with timer at 10.
      blink_mask = 3'b111;
      pulse_sel(2);
      for (int n = 1; n <= 10; n++) step();
      reset = 1'b1;
      step();
      check("midrst_cur", 64'(cur_sel), 64'd0);
      check("midrst_dig", 64'(dig_out), 64'd0);
      check("midrst_pulse", 64'(timeout_pulse), 64'd0);
      reset = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         check("midrst_no_pulse", 64'(timeout_pulse), 64'd0);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         sel_valid  = ($urandom_range(99, 0) < 20);
         sel        = SEL_W'($urandom_range(3, 0));
         blink_mask = NUM_DIG'($urandom_range(7, 0));
         reset      = ($urandom_range(99, 0) < 2);
         if ($urandom_range(9, 0) == 0) begin
            rnd = {$urandom(), $urandom()};
            src_data = rnd[SRC_W-1:0];
         end
         step();
      end
      reset = 1'b0; sel_valid = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/display_selector.md
DISPLAY_SELECTOR -- requirements
Module: display_selector

Interface
REQ-001 Parameter NUM_SRC, default 3: number of display sources; SHALL be >= 2.
REQ-002 Parameter NUM_DIG, default 3: digit groups per source.
REQ-003 Parameter DIG_W, default 7: bits per digit group.
REQ-004 Parameter TIMEOUT, default 16: idle cycles before automatic return to source 0; SHALL be >= 2.
REQ-005 Parameter BLINK_HALF, default 4: cycles per blink half-period; SHALL be >= 1.
REQ-006 Parameter BLANK, DIG_W bits, default all zeros: value driven for a blanked digit group.
REQ-007 Localparam SEL_W = clog2(NUM_SRC), minimum 1.
REQ-008 clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 src_data  input  NUM_SRC*NUM_DIG*DIG_W  flat source bus; source s, digit d at bit offset (s*NUM_DIG+d)*DIG_W.
REQ-011 sel  input  SEL_W  requested source index.
REQ-012 sel_valid  input  1  single-cycle strobe qualifying sel.
REQ-013 blink_mask  input  NUM_DIG  digit groups to blink while a non-zero source is selected.
REQ-014 dig_out  output  NUM_DIG*DIG_W  registered display value, same digit layout as one source.
REQ-015 cur_sel  output  SEL_W  currently selected source, registered.
REQ-016 timeout_pulse  output  1  one-cycle pulse on automatic return to source 0.

Function
REQ-017 sel_valid=1 with sel < NUM_SRC SHALL be accepted: cur_sel <= sel at that edge.
REQ-018 sel_valid=1 with sel >= NUM_SRC SHALL be ignored: no change to cur_sel, timer, or blink state.
REQ-019 Idle timer SHALL be cleared to 0 on every accepted select, including sel equal to cur_sel.
REQ-020 Idle timer SHALL increment each cycle while cur_sel != 0 and no select is accepted, and SHALL hold at 0 while cur_sel == 0.
REQ-021 Timer == TIMEOUT-1 with no accepted select SHALL, at the next edge, set cur_sel <= 0, clear the timer, and drive timeout_pulse=1 for exactly one cycle; net result: revert TIMEOUT edges after the last accepted select.
REQ-022 An accepted select in the same cycle as the timeout condition SHALL win: no revert, no pulse, timer cleared.
REQ-023 Blink counter SHALL count 0..BLINK_HALF-1 and wrap; phase SHALL toggle on each wrap; phase=1 means visible.
REQ-024 An accepted select SHALL clear the blink counter and set phase=1.
REQ-025 dig_out SHALL be registered from the current-cycle cur_sel, phase, blink_mask and src_data; one-cycle latency, two edges from sel_valid to new source on dig_out.
REQ-026 Digit group d SHALL be BLANK when cur_sel != 0, phase=0 and blink_mask[d]=1; otherwise it SHALL be the src_data digit d of source cur_sel.
REQ-027 Source 0 SHALL never blink, regardless of blink_mask.
REQ-028 src_data changes SHALL reach dig_out after one edge with no other side effect.

Reset
REQ-029 reset=1 SHALL at the next edge set cur_sel=0, timer=0, blink counter=0, phase=1, timeout_pulse=0, dig_out=all zeros.
REQ-030 reset SHALL take priority over sel_valid and the timeout condition, including mid-timeout or mid-blink.
REQ-031 The first edge after reset deasserts SHALL load dig_out from source 0.

Verification (defaults; source s digit d = 7'h10*s+d)
REQ-032 Reset 2 cycles, release -> cur_sel=0 and dig_out=0 during reset; one edge later dig_out = {7'h02,7'h01,7'h00}; timeout_pulse never asserted while idle on source 0.
REQ-033 sel=2 pulse at edge k -> cur_sel=2 at k, dig_out = source 2 at k+1; no further selects -> cur_sel=0 and timeout_pulse=1 at k+16 only, dig_out = source 0 at k+17.
REQ-034 sel=1, blink_mask=3'b010 -> digit 1 alternates 7'h11 / BLANK every 4 cycles, starting visible; digits 0 and 2 stay steady. sel=0 with the same mask -> no blinking.
REQ-035 sel=3 (out of range) while on source 1 -> cur_sel, blink phase and timer unchanged; revert still at original k+16.
REQ-036 sel_valid=1, sel=1 on the exact timeout cycle -> no pulse, cur_sel stays 1, next revert 16 edges later.
REQ-037 reset during source 2 blink at timer=10 -> all state per REQ-029; no timeout_pulse afterwards.
